// File: rtl/wimax_block_interleaver.sv
// rtl/wimax_block_interleaver.sv - 802.16 QPSK first-permutation bit interleaver, ping-pong banks
// Optional block markers out_first_o/out_last_o are enabled by defining INTLV_BLOCK_MARK_EN.
module wimax_block_interleaver #(
  parameter int NCBPS = 384,
  parameter int OUT_W = 2,
  parameter int AW    = $clog2(NCBPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_bit_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
`ifdef INTLV_BLOCK_MARK_EN
  ,
  output logic             out_first_o,
  output logic             out_last_o
`endif
);

  localparam int ROWS = NCBPS / 12;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [AW-1:0] RADDR_LAST = AW'(NCBPS - OUT_W);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;

  bank_state_e      state_q [2];
  bank_state_e      state_d [2];
  logic             wbank_q, wbank_d;
  logic [3:0]       col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic             rbank_q, rbank_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bank_q, out_bank_d;
  logic             out_last_q, out_last_d;
`ifdef INTLV_BLOCK_MARK_EN
  logic             out_first_q, out_first_d;
`endif
  logic [NCBPS-1:0] mem_q [2];

  logic wr_en, last_k, accept, load;

  assign in_ready_o = (state_q[wbank_q] == EMPTY) || (state_q[wbank_q] == FILLING);
  assign wr_en      = in_valid_i && in_ready_o;
  assign last_k     = (col_q == 4'd11) && (row_q == RW'(ROWS - 1));
  assign accept     = out_valid_q && out_ready_i;
  // rbank moves on as soon as the last beat of a bank is loaded, so the next
  // FULL bank can follow without a bubble; the old bank is released on accept.
  assign load       = ((state_q[rbank_q] == FULL) || (state_q[rbank_q] == DRAINING))
                      && (!out_valid_q || out_ready_i);

  always_comb begin
    state_d     = state_q;
    wbank_d     = wbank_q;
    col_d       = col_q;
    row_d       = row_q;
    waddr_d     = waddr_q;
    rbank_d     = rbank_q;
    raddr_d     = raddr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_bank_d  = out_bank_q;
    out_last_d  = out_last_q;
`ifdef INTLV_BLOCK_MARK_EN
    out_first_d = out_first_q;
`endif

    if (accept && out_last_q) state_d[out_bank_q] = EMPTY;

    if (wr_en) begin
      if (state_q[wbank_q] == EMPTY) state_d[wbank_q] = FILLING;
      if (last_k) begin
        state_d[wbank_q] = FULL;
        wbank_d          = ~wbank_q;
        col_d            = '0;
        row_d            = '0;
        waddr_d          = '0;
      end else if (col_q != 4'd11) begin
        col_d   = col_q + 4'd1;
        waddr_d = waddr_q + AW'(ROWS);
      end else begin
        col_d   = '0;
        row_d   = row_q + RW'(1);
        waddr_d = AW'(row_q) + AW'(1);
      end
    end

    if (load) begin
      state_d[rbank_q] = DRAINING;
      out_data_d       = mem_q[rbank_q][raddr_q +: OUT_W];
      out_valid_d      = 1'b1;
      out_bank_d       = rbank_q;
      out_last_d       = (raddr_q == RADDR_LAST);
`ifdef INTLV_BLOCK_MARK_EN
      out_first_d      = (raddr_q == '0);
`endif
      if (raddr_q == RADDR_LAST) begin
        rbank_d = ~rbank_q;
        raddr_d = '0;
      end else begin
        raddr_d = raddr_q + AW'(OUT_W);
      end
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wbank_q     <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      waddr_q     <= '0;
      rbank_q     <= 1'b0;
      raddr_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_bank_q  <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef INTLV_BLOCK_MARK_EN
      out_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wbank_q     <= wbank_d;
      col_q       <= col_d;
      row_q       <= row_d;
      waddr_q     <= waddr_d;
      rbank_q     <= rbank_d;
      raddr_q     <= raddr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_bank_q  <= out_bank_d;
      out_last_q  <= out_last_d;
`ifdef INTLV_BLOCK_MARK_EN
      out_first_q <= out_first_d;
`endif
    end
  end

  // Bank storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wbank_q][waddr_q] <= in_bit_i;
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
`ifdef INTLV_BLOCK_MARK_EN
  assign out_first_o = out_first_q;
  assign out_last_o  = out_last_q;
`endif

endmodule

// File: tb/tb_wimax_block_interleaver.sv
// tb/tb_wimax_block_interleaver.sv - directed bench for wimax_block_interleaver
module tb_wimax_block_interleaver;
  localparam int N     = 384;
  localparam int ROWS  = N / 12;
  localparam int BEATS = N / 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_bit_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic       in_ready_o, out_valid_o;
  logic [1:0] out_data_o;
`ifdef INTLV_BLOCK_MARK_EN
  logic       out_first_o, out_last_o;
  bit         rxf_q[$], rxl_q[$];
`endif

  int         checks = 0, failures = 0, cyc = 0;
  int         first_valid_cyc = -1, in_stalls = 0;
  int         wr_last_cyc [10];
  bit         src [10][N];
  logic [1:0] exp_q[$], rx_q[$];
  int         rx_cyc[$];
  bit         feed_done;

  wimax_block_interleaver #(.NCBPS(N), .OUT_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_bit_i(in_bit_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
`ifdef INTLV_BLOCK_MARK_EN
    , .out_first_o(out_first_o), .out_last_o(out_last_o)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (!reset && out_valid_o && out_ready_i) begin
      rx_q.push_back(out_data_o);
      rx_cyc.push_back(cyc);
`ifdef INTLV_BLOCK_MARK_EN
      rxf_q.push_back(out_first_o);
      rxl_q.push_back(out_last_o);
`endif
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_rx();
    rx_q.delete(); rx_cyc.delete(); exp_q.delete();
`ifdef INTLV_BLOCK_MARK_EN
    rxf_q.delete(); rxl_q.delete();
`endif
    first_valid_cyc = -1;
    in_stalls = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid_i = 1'b0; in_bit_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_rx();
  endtask

  // Reference: output position m_k = ROWS*(k mod 12) + floor(k/12).
  task automatic add_expected(input int b);
    bit o [N];
    for (int k = 0; k < N; k++) o[ROWS * (k % 12) + k / 12] = src[b][k];
    for (int j = 0; j < BEATS; j++) exp_q.push_back({o[2*j+1], o[2*j]});
  endtask

  task automatic fill(input int b, input int mode);
    for (int k = 0; k < N; k++) src[b][k] = (mode == 0) ? 1'b0 : 1'($urandom_range(1));
  endtask

  task automatic feed(input int b0, input int nbits, input int pct);
    int  w;
    bit  go;
    for (int i = 0; i < nbits; i++) begin
      w = 0;
      do begin
        in_bit_i   = src[b0 + i / N][i % N];
        in_valid_i = (pct >= 100) ? 1'b1 : 1'($urandom_range(99) < pct);
        @(negedge clk);
        go = in_valid_i && in_ready_o;
        if (in_valid_i && !in_ready_o) in_stalls++;
        @(posedge clk); #1;
        w++;
      end while (!go && w < 5000);
      if (!go) begin
        checks++; failures++;
        $display("FAIL feed_timeout bit=%0d got=stalled want=accepted", i);
        in_valid_i = 1'b0;
        return;
      end
      if (i % N == N - 1) wr_last_cyc[b0 + i / N] = cyc;
    end
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || out_data_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_values got=rdy%b vld%b data%b want=rdy1 vld0 data00", in_ready_o, out_valid_o, out_data_o);
    end
    do_reset();
  endtask

  task automatic test_permutation();
    int t = 0, nz = 0;
    do_reset();
    fill(0, 0); src[0][13] = 1'b1;
    add_expected(0);
    out_ready_i = 1'b1;
    feed(0, N, 100);
    while (rx_q.size() < BEATS && t < 2000) begin @(posedge clk); #1; t++; end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rx_q.size() != BEATS) begin failures++; $display("FAIL perm_count got=%0d want=%0d", rx_q.size(), BEATS); end
    checks++;
    if (rx_q[16] !== 2'b10) begin failures++; $display("FAIL perm_beat16 got=%b want=10", rx_q[16]); end
    foreach (rx_q[i]) if (rx_q[i] !== 2'b00) nz++;
    checks++;
    if (nz != 1) begin failures++; $display("FAIL perm_nonzero got=%0d want=1", nz); end
  endtask

  task automatic test_pairing();
    int t = 0, nz = 0;
    do_reset();
    fill(1, 0); src[1][0] = 1'b1; src[1][12] = 1'b1;
    out_ready_i = 1'b1;
    feed(1, N, 100);
    while (rx_q.size() < BEATS && t < 2000) begin @(posedge clk); #1; t++; end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rx_q.size() != BEATS) begin failures++; $display("FAIL pair_count got=%0d want=%0d", rx_q.size(), BEATS); end
    checks++;
    if (rx_q[0] !== 2'b11) begin failures++; $display("FAIL pair_beat0 got=%b want=11", rx_q[0]); end
    foreach (rx_q[i]) if (rx_q[i] !== 2'b00) nz++;
    checks++;
    if (nz != 1) begin failures++; $display("FAIL pair_nonzero got=%0d want=1", nz); end
  endtask

  task automatic test_back_to_back();
    int t = 0;
    do_reset();
    for (int b = 0; b < 3; b++) begin fill(b, 1); add_expected(b); end
    out_ready_i = 1'b1;
    feed(0, 3 * N, 100);
    while (rx_q.size() < 3 * BEATS && t < 2000) begin @(posedge clk); #1; t++; end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rx_q.size() != 3 * BEATS) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", rx_q.size(), 3 * BEATS); end
    checks++;
    if (in_stalls != 0) begin failures++; $display("FAIL b2b_in_ready got=%0d stalls want=0", in_stalls); end
    checks++;
    if (first_valid_cyc != wr_last_cyc[0] + 1) begin
      failures++; $display("FAIL b2b_latency got=%0d want=%0d", first_valid_cyc, wr_last_cyc[0] + 1);
    end
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (rx_cyc[b*BEATS] != wr_last_cyc[b] + 1 || rx_cyc[b*BEATS + BEATS - 1] != rx_cyc[b*BEATS] + BEATS - 1) begin
        failures++;
        $display("FAIL b2b_burst%0d got=start%0d end%0d want=start%0d contiguous", b, rx_cyc[b*BEATS], rx_cyc[b*BEATS + BEATS - 1], wr_last_cyc[b] + 1);
      end
    end
    foreach (exp_q[i]) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_data beat=%0d got=%b want=%b", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int t = 0, bad = 0;
    do_reset();
    for (int b = 3; b < 5; b++) begin fill(b, 1); add_expected(b); end
    out_ready_i = 1'b0;
    feed(3, 2 * N, 100);
    checks++;
    if (in_stalls != 0) begin failures++; $display("FAIL bp_accept got=%0d stalls want=0", in_stalls); end
    checks++;
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low got=%b want=0", in_ready_o); end
    for (int i = 0; i < 5; i++) begin
      if (out_valid_o !== 1'b1 || out_data_o !== exp_q[0]) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold got=%0d unstable want=0 data=%b", bad, exp_q[0]); end
    out_ready_i = 1'b1;
    while (rx_q.size() < BEATS - 1 && t < 1000) begin @(posedge clk); #1; t++; end
    checks++;
    if (in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_before_release got=%b want=0", in_ready_o); end
    @(posedge clk); #1;
    checks++;
    if (rx_q.size() != BEATS || in_ready_o !== 1'b1) begin
      failures++; $display("FAIL bp_release got=beats%0d rdy%b want=beats%0d rdy1", rx_q.size(), in_ready_o, BEATS);
    end
    t = 0;
    while (rx_q.size() < 2 * BEATS && t < 1000) begin @(posedge clk); #1; t++; end
    foreach (exp_q[i]) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_data beat=%0d got=%b want=%b", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_stall();
    int t = 0;
    do_reset();
    for (int b = 0; b < 10; b++) begin fill(b, 1); add_expected(b); end
    feed_done = 1'b0;
    fork
      begin feed(0, 10 * N, 50); feed_done = 1'b1; end
      begin
        while (!feed_done) begin out_ready_i = 1'($urandom_range(1)); @(posedge clk); #1; end
      end
    join
    out_ready_i = 1'b1;
    while (rx_q.size() < 10 * BEATS && t < 5000) begin @(posedge clk); #1; t++; end
    repeat (4) @(posedge clk); #1;
    checks++;
    if (rx_q.size() != 10 * BEATS) begin failures++; $display("FAIL rnd_count got=%0d want=%0d", rx_q.size(), 10 * BEATS); end
    foreach (exp_q[i]) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_data beat=%0d got=%b want=%b", i, rx_q[i], exp_q[i]); end
`ifdef INTLV_BLOCK_MARK_EN
      checks++;
      if (rxf_q[i] != (i % BEATS == 0) || rxl_q[i] != (i % BEATS == BEATS - 1)) begin
        failures++; $display("FAIL rnd_marks beat=%0d got=f%b l%b want=f%b l%b", i, rxf_q[i], rxl_q[i], i % BEATS == 0, i % BEATS == BEATS - 1);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_block();
    int t = 0;
    do_reset();
    fill(5, 1); fill(6, 1); fill(7, 1);
    out_ready_i = 1'b0;
    feed(5, N + 200, 100);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++; $display("FAIL mid_reset got=vld%b rdy%b want=vld0 rdy1", out_valid_o, in_ready_o);
    end
    @(posedge clk); #1 reset = 1'b0;
    clear_rx();
    add_expected(7);
    out_ready_i = 1'b1;
    feed(7, N, 100);
    while (rx_q.size() < BEATS && t < 2000) begin @(posedge clk); #1; t++; end
    repeat (20) @(posedge clk); #1;
    checks++;
    if (rx_q.size() != BEATS) begin failures++; $display("FAIL mid_count got=%0d want=%0d", rx_q.size(), BEATS); end
    foreach (exp_q[i]) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL mid_data beat=%0d got=%b want=%b", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_permutation();
    test_pairing();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_mid_block();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wimax_block_interleaver.md
Name: wimax_block_interleaver

Overview:
- Per-block bit interleaver for the 802.16 OFDM TX chain.
- Sits between the convolutional encoder (1 coded bit/beat in) and const_mapping (OUT_W bits/beat out).
- Applies the first 802.16 permutation m_k = (NCBPS/12)*(k mod 12) + floor(k/12), with d=12. QPSK only (s=1), so the second permutation is identity.
- Ping-pong buffered: one bank fills while the other drains, giving continuous throughput.

Parameters:
- NCBPS, 384, coded bits per OFDM block; must be a multiple of 12 and of OUT_W.
- OUT_W, 2, bits per output beat (one QPSK symbol).
- AW, clog2(NCBPS), bank address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- in_bit  in  1  coded bit k.
- in_valid  in  1  in_bit valid.
- in_ready  out  1  interleaver can accept in_bit.
- out_data  out  OUT_W  interleaved bits; out_data[0] is the earlier output position.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset clears all bank states, counters and the output register. Reset values: in_ready=1, out_valid=0, out_data=0. Bank memory contents are not cleared.
- Reset mid-block discards all partial and full blocks. The first input after reset is k=0 into bank 0.
- Each bank has a 2-bit state: EMPTY -> FILLING (first write) -> FULL (k=NCBPS-1 written) -> DRAINING (first read) -> EMPTY (last beat accepted).
- Writer holds wbank, col (0..11), row (0..NCBPS/12-1) and waddr.
  - Write occurs when in_valid && in_ready: mem[wbank][waddr] <= in_bit.
  - If col<11: col++ and waddr += NCBPS/12.
  - Else: col=0, row++, waddr = row+1.
  - On k=NCBPS-1: bank goes FULL, wbank toggles, col/row/waddr go to 0.
  - No multiplier is used; the address update is incremental.
- in_ready = (state[wbank]==EMPTY || state[wbank]==FILLING). It is derived from registered state, so a bank released by the reader shows up as in_ready=1 the cycle after the release.
- Reader holds rbank and raddr, and reads OUT_W consecutive addresses per beat.
  - out_data/out_valid are registered (show-ahead).
  - When state[rbank]==FULL and the output register is empty or being accepted, load mem[rbank][raddr +: OUT_W] and set out_valid.
- Latency: the last bit of a block is written at edge t; out_valid=1 with beat 0 at edge t+1.
- Output handshake: a beat transfers on out_valid && out_ready.
  - With out_ready held high, one beat issues per cycle with no bubbles, including across bank switches when the next bank is FULL.
  - While out_valid && !out_ready, out_data and out_valid hold stable.
- Drain end: when the beat at raddr = NCBPS-OUT_W is accepted, the bank goes EMPTY, rbank toggles and raddr=0. out_valid drops unless the other bank is FULL.
- Write into bank X and release of bank Y in the same cycle: both take effect; there is no conflict because X≠Y.
- Writer cannot overtake reader: the writer stalls (in_ready=0) when its target bank is FULL or DRAINING.
- An in_valid drop mid-block simply pauses the counters. There is no timeout.

Optional Feature:
- INTLV_BLOCK_MARK_EN: adds output ports out_first and out_last (1 bit each), registered alongside out_data.
  - out_first=1 on beat 0 of a block.
  - out_last=1 on beat NCBPS/OUT_W-1.
  - Both are 0 at reset and held during stalls.
  - Without the macro, the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Permutation, NCBPS=384, OUT_W=2: feed a one-hot at k=13 -> the single 1 appears at output position 33, i.e. beat 16, out_data=2'b10. All other beats are 0.
- Pairing: feed in_bit=1 at k=0 and k=12 only -> beat 0 out_data=2'b11; beats 1..191 are 0.
- Latency and throughput: feed 3 blocks back-to-back with out_ready=1 -> out_valid rises exactly 1 cycle after the k=383 write. 576 consecutive valid beats follow with no gaps. in_ready never drops.
- Backpressure: out_ready=0 while 2 blocks are written -> in_ready=0 after k=383 of block 2 with 768 bits accepted, and out_data stays stable. Raising out_ready drains 192 beats, then in_ready=1 the next cycle.
- Random stall: random in_valid/out_ready (50%) over 10 blocks -> output matches the reference permutation model bit-exact.
- Reset mid-block: assert reset at k=200 of block 1 while block 0 is draining -> out_valid=0 and in_ready=1 immediately. A new block then emerges correctly, with no stale data.
